// File: rtl/l2_sq_accumulator.sv
// Sum-of-squares partial-sum stage of the L2-norm datapath.
// Registers each sample, squares it and folds it into a wrapping accumulator.
module l2_sq_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic             valid_in,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             overflow
);

  localparam int PW = 2 * IN_W;

  logic [IN_W-1:0]  r_a_q;
  logic             r_valid_q;
  logic [ACC_W-1:0] r_f;
  logic             r_valid_out;
  logic             r_overflow;

  logic signed [PW-1:0] w_prod;
  logic [ACC_W:0]       w_prod_ext;
  logic [ACC_W:0]       w_sum;
  logic                 w_ovf;

  assign w_prod = $signed(r_a_q) * $signed(r_a_q);
  assign w_prod_ext = {{(ACC_W + 1 - PW){w_prod[PW-1]}}, w_prod};
  assign w_sum = {r_f[ACC_W-1], r_f} + w_prod_ext;
  // Extra sum bit disagreeing with the result sign means signed range was left.
  assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_q     <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_a_q     <= a;
      r_valid_q <= valid_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f         <= '0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_valid_out <= r_valid_q;
      if (r_valid_q) begin
        r_f <= w_sum[ACC_W-1:0];
        if (w_ovf) r_overflow <= 1'b1;
      end
    end
  end

  assign f         = r_f;
  assign valid_out = r_valid_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_l2_sq_accumulator.sv
// Bench for l2_sq_accumulator: vector table plus scoreboard
// of expected results tagged with the cycle they are due.
module tb_l2_sq_accumulator;

  localparam int IN_W  = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [IN_W-1:0]  a = '0;
  logic             valid_in = 1'b0;
  logic [ACC_W-1:0] f;
  logic             valid_out;
  logic             overflow;

  typedef struct {
    logic [ACC_W-1:0] f;
    logic             ovf;
    int               due;
  } exp_t;

  typedef struct {
    bit               rst;
    logic [IN_W-1:0]  a;
    logic             v;
    logic [ACC_W-1:0] ef;
    logic             eo;
  } vec_t;

  exp_t q[$];
  vec_t tab[16];

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0;
  int m_acc = 0;
  logic m_ovf = 1'b0;
  logic [ACC_W-1:0] h_f = '0;
  logic h_ovf = 1'b0;

  always #5 clk = ~clk;

  l2_sq_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .valid_in  (valid_in),
    .f         (f),
    .valid_out (valid_out),
    .overflow  (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic [IN_W-1:0] x, input logic v,
                     input bit use_tab, input logic [ACC_W-1:0] tf,
                     input logic to);
    exp_t e;
    int xs;
    int t;
    @(negedge clk);
    n_cyc++;
    if (valid_out === 1'b1) begin
      if (q.size() == 0 || q[0].due != n_cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_valid_out cyc %0d f %0h", n_cyc, f);
      end else begin
        e = q.pop_front();
        chk("acc_f", {12'd0, f}, {12'd0, e.f});
        chk("acc_ovf", {31'd0, overflow}, {31'd0, e.ovf});
        h_f = e.f;
        h_ovf = e.ovf;
      end
    end else if (q.size() > 0 && q[0].due == n_cyc) begin
      e = q.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL missing_valid_out cyc %0d got %b want 1", n_cyc, valid_out);
      h_f = e.f;
      h_ovf = e.ovf;
    end else begin
      chk("hold_vout", {31'd0, valid_out}, 32'd0);
      chk("hold_f", {12'd0, f}, {12'd0, h_f});
      chk("hold_ovf", {31'd0, overflow}, {31'd0, h_ovf});
    end
    a = x;
    valid_in = v;
    if (v) begin
      xs = int'($signed(x));
      t = m_acc + xs * xs;
      if (t > 524287) begin
        m_ovf = 1'b1;
        t = t - 1048576;
      end
      m_acc = t;
      e.f = use_tab ? tf : t[ACC_W-1:0];
      e.ovf = use_tab ? to : m_ovf;
      e.due = n_cyc + 2;
      q.push_back(e);
    end
  endtask

  task automatic drv(input logic [IN_W-1:0] x, input logic v);
    cyc(x, v, 1'b0, '0, 1'b0);
  endtask

  task automatic flush();
    for (int i = 0; i < 8 && q.size() > 0; i++) drv(8'd0, 1'b0);
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL flush_timeout pending %0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    a = 8'h55;
    valid_in = 1'b1;
    #1;
    chk("async_rst_f", {12'd0, f}, 32'd0);
    chk("async_rst_vout", {31'd0, valid_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f", {12'd0, f}, 32'd0);
    chk("rst_vout", {31'd0, valid_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    a = '0;
    q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    h_f = '0;
    h_ovf = 1'b0;
  endtask

  initial begin
    tab[0]  = '{0, 8'd1,   1'b1, 20'd1,  1'b0};
    tab[1]  = '{0, 8'd2,   1'b1, 20'd5,  1'b0};
    tab[2]  = '{0, 8'd3,   1'b1, 20'd14, 1'b0};
    tab[3]  = '{0, 8'd0,   1'b0, 20'd0,  1'b0};
    tab[4]  = '{0, 8'd0,   1'b0, 20'd0,  1'b0};
    tab[5]  = '{1, 8'd0,   1'b0, 20'd0,  1'b0};
    tab[6]  = '{0, 8'hFB,  1'b1, 20'd25, 1'b0};
    for (int i = 7; i < 14; i++) tab[i] = '{0, 8'h80, 1'b0, 20'd0, 1'b0};
    tab[14] = '{0, 8'd4,   1'b1, 20'd41, 1'b0};
    tab[15] = '{0, 8'd9,   1'b0, 20'd0,  1'b0};

    do_reset();
    repeat (4) drv(8'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (tab[i].rst) do_reset();
      else cyc(tab[i].a, tab[i].v, 1'b1, tab[i].ef, tab[i].eo);
    end
    flush();
    chk("gap_final_f", {12'd0, f}, 32'd41);

    for (int i = 0; i < 256; i++) drv(8'(i), 1'b0);
    chk("sweep_f", {12'd0, f}, 32'd41);

    drv(8'd10, 1'b1);
    do_reset();
    repeat (3) drv(8'd0, 1'b0);
    chk("discard_f", {12'd0, f}, 32'd0);

    do_reset();
    drv(8'd2, 1'b1);
    repeat (2) drv(8'd7, 1'b0);
    flush();
    chk("burst1_f", {12'd0, f}, 32'd4);
    repeat (3) drv(8'd0, 1'b0);
    repeat (2) drv(8'd2, 1'b1);
    drv(8'd0, 1'b0);
    flush();
    chk("burst2_f", {12'd0, f}, 32'd12);
    drv(8'd0, 1'b0);
    repeat (5) drv(8'd2, 1'b1);
    flush();
    chk("burst5_f", {12'd0, f}, 32'd32);

    do_reset();
    repeat (31) drv(8'h80, 1'b1);
    flush();
    chk("pre_ovf_f", {12'd0, f}, 32'd507904);
    chk("pre_ovf_flag", {31'd0, overflow}, 32'd0);
    drv(8'h80, 1'b1);
    flush();
    chk("ovf_f", {12'd0, f}, 32'h80000);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    repeat (3) drv(8'h80, 1'b1);
    flush();
    chk("post_ovf_f", {12'd0, f}, 32'd573440);
    chk("post_ovf_flag", {31'd0, overflow}, 32'd1);
    do_reset();
    drv(8'd0, 1'b0);
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
